scan_scheduler: RTL and testbench

SCAN_SCHEDULER -- requirements
Module: scan_scheduler

---
 rtl/scan_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_scan_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scan_scheduler.sv
// Multiplexed 7-segment scan scheduler: IDLE/BLANK/SHOW sequencer with registered outputs.
// Optional SCAN_FRAME_LATCH_EN snapshots the display inputs once per frame at digit 0.
module scan_scheduler #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DEAD_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_tick,
  input  logic                    blink_tick,
  input  logic                    disp_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   flash_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_start
);

  localparam int unsigned    IdxW     = $clog2(NUM_DIGITS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
  localparam logic [7:0]     DeadLast = 8'(DEAD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [7:0]              dead_q, dead_d;
  logic                    blink_q, blink_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    fs_q, fs_d;
  // Pixel and dark controls captured for the digit currently shown.
  logic [7:0]              raw_q, raw_d;
  logic                    cur_blank_q, cur_blank_d;
  logic                    cur_flash_q, cur_flash_d;
  logic                    load_show;

  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dp, src_blank, src_flash;

`ifdef SCAN_FRAME_LATCH_EN
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_blank_q, snap_flash_q;

  // Digit 0 reads live inputs (the values being snapshotted); later digits read the snapshot.
  always_comb begin
    if (idx_q == '0) begin
      src_digits = digits;
      src_dp     = dp_mask;
      src_blank  = blank_mask;
      src_flash  = flash_mask;
    end else begin
      src_digits = snap_digits_q;
      src_dp     = snap_dp_q;
      src_blank  = snap_blank_q;
      src_flash  = snap_flash_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      snap_flash_q  <= '0;
    end else if (load_show && idx_q == '0) begin
      snap_digits_q <= digits;
      snap_dp_q     <= dp_mask;
      snap_blank_q  <= blank_mask;
      snap_flash_q  <= flash_mask;
    end
  end
`else
  assign src_digits = digits;
  assign src_dp     = dp_mask;
  assign src_blank  = blank_mask;
  assign src_flash  = flash_mask;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic [3:0]            sel_nib;
  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    sel_nib        = src_digits[{idx_q, 2'b00} +: 4];
    onehot         = '0;
    onehot[idx_q]  = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dead_d      = dead_q;
    blink_d     = blink_q ^ blink_tick;
    an_d        = '0;
    seg_d       = '0;
    fs_d        = 1'b0;
    raw_d       = raw_q;
    cur_blank_d = cur_blank_q;
    cur_flash_d = cur_flash_q;
    load_show   = 1'b0;

    if (!disp_en) begin
      state_d = StIdle;
      idx_d   = '0;
      dead_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = '0;
          dead_d  = '0;
        end
        StBlank: begin
          if (dead_q == DeadLast) begin
            state_d     = StShow;
            load_show   = 1'b1;
            raw_d       = {src_dp[idx_q], hex7(sel_nib)};
            cur_blank_d = src_blank[idx_q];
            cur_flash_d = src_flash[idx_q];
            an_d        = onehot;
            seg_d       = (cur_blank_d || (cur_flash_d && blink_d)) ? 8'h00 : raw_d;
            fs_d        = (idx_q == '0);
          end else begin
            dead_d = dead_q + 8'd1;
          end
        end
        StShow: begin
          if (scan_tick) begin
            state_d = StBlank;
            dead_d  = '0;
            idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
          end else begin
            an_d  = onehot;
            // Dark test uses the next blink phase so seg tracks the phase register.
            seg_d = (cur_blank_q || (cur_flash_q && blink_d)) ? 8'h00 : raw_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      dead_q      <= '0;
      blink_q     <= 1'b0;
      an_q        <= '0;
      seg_q       <= '0;
      fs_q        <= 1'b0;
      raw_q       <= '0;
      cur_blank_q <= 1'b0;
      cur_flash_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dead_q      <= dead_d;
      blink_q     <= blink_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      fs_q        <= fs_d;
      raw_q       <= raw_d;
      cur_blank_q <= cur_blank_d;
      cur_flash_q <= cur_flash_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed self-checking bench for scan_scheduler (NUM_DIGITS=8, DEAD_CYC=16).
module tb_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_tick = 1'b0;
  logic        blink_tick = 1'b0;
  logic        disp_en = 1'b0;
  logic [31:0] digits = 32'h7654_3210;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  blank_mask = 8'h00;
  logic [7:0]  flash_mask = 8'h00;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  scan_scheduler #(
    .NUM_DIGITS(8),
    .DEAD_CYC  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_tick  (scan_tick),
    .blink_tick (blink_tick),
    .disp_en    (disp_en),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .flash_mask (flash_mask),
    .an         (an),
    .seg        (seg),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n cycles with every anode off and no frame pulse.
  task automatic dark(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, {23'd0, frame_start, an}, 32'd0);
    end
  endtask

  task automatic scan_to(input string tag, input logic [7:0] ean, input logic [7:0] eseg,
                         input logic efs);
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    check({tag, "_dark0"}, {23'd0, frame_start, an}, 32'd0);
    dark({tag, "_dark"}, 15);
    step();
    check({tag, "_an"}, an, ean);
    check({tag, "_seg"}, seg, eseg);
    check({tag, "_fs"}, frame_start, efs);
  endtask

  logic [7:0] exp_an  [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] exp_seg [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'hBF};
  logic [7:0] exp_d1;

  initial begin
    // Reset state
    step();
    check("rst_an", an, 8'h00);
    check("rst_seg", seg, 8'h00);
    check("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_an", an, 8'h00);
    check("idle_seg", seg, 8'h00);

    // Enable: 16 dark cycles then digit 0
    disp_en = 1'b1;
    dark("en_dark", 16);
    step();
    check("first_an", an, 8'h01);
    check("first_seg", seg, 8'h3F);
    check("first_fs", frame_start, 1'b1);
    step();
    check("fs_single", frame_start, 1'b0);
    check("hold_an", an, 8'h01);

    // Full frame; digit 0 gets dp and flash for the wrap
    dp_mask    = 8'h01;
    flash_mask = 8'h01;
    for (int i = 0; i < 8; i++) begin
      scan_to("frame", exp_an[i], exp_seg[i], (i == 7));
    end

    // Blink: phase 1 darkens digit 0 (including dp), phase 0 restores
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    check("blink1_seg", seg, 8'h00);
    check("blink1_an", an, 8'h01);
    step();
    check("blink1_hold", seg, 8'h00);
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    check("blink0_seg", seg, 8'hBF);

    // scan_tick in BLANK ignored, simultaneous blink_tick still toggles phase
    flash_mask = 8'h03;
    scan_tick  = 1'b1;
    step();
    scan_tick = 1'b0;
    dark("ign_dark_a", 4);
    scan_tick  = 1'b1;
    blink_tick = 1'b1;
    step();
    scan_tick  = 1'b0;
    blink_tick = 1'b0;
    check("ign_dark_b", an, 8'h00);
    dark("ign_dark_c", 10);
    step();
    check("ign_an", an, 8'h02);
    check("ign_seg_dark", seg, 8'h00);
    flash_mask = 8'h00;

    // Advance to index 5, then drop disp_en
    scan_to("to2", 8'h04, 8'h5B, 1'b0);
    scan_to("to3", 8'h08, 8'h4F, 1'b0);
    scan_to("to4", 8'h10, 8'h66, 1'b0);
    scan_to("to5", 8'h20, 8'h6D, 1'b0);
    disp_en = 1'b0;
    step();
    check("off_an", an, 8'h00);
    check("off_seg", seg, 8'h00);
    step();
    disp_en = 1'b1;
    dark("reen_dark", 16);
    step();
    check("reen_an", an, 8'h01);
    check("reen_seg", seg, 8'hBF);
    check("reen_fs", frame_start, 1'b1);

    // Mid-frame digit change
    digits = 32'h7654_3298;
`ifdef SCAN_FRAME_LATCH_EN
    exp_d1 = 8'h06;
`else
    exp_d1 = 8'h6F;
`endif
    scan_to("live", 8'h02, exp_d1, 1'b0);

    // Asynchronous reset mid-frame, then clean restart at digit 0
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an", an, 8'h00);
    check("arst_seg", seg, 8'h00);
    check("arst_fs", frame_start, 1'b0);
    step();
    rst_n = 1'b1;
    dark("rs_dark", 16);
    step();
    check("rs_an", an, 8'h01);
    check("rs_seg", seg, 8'hFF);
    check("rs_fs", frame_start, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
